// File: rtl/div_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : div_pkg
//  Description : Shared encodings for the multi-cycle divider and the EX-stage
//                logic that drives it (FSM states, handshake levels, aluops).
//  Revision    : 1.0  initial release
// ============================================================================
package div_pkg;

    // Divider FSM state encodings
    localparam logic [1:0] DIV_FREE   = 2'b00;
    localparam logic [1:0] DIV_BYZERO = 2'b01;
    localparam logic [1:0] DIV_ON     = 2'b10;
    localparam logic [1:0] DIV_END    = 2'b11;

    // Result-valid levels
    localparam logic DIV_RESULT_READY     = 1'b1;
    localparam logic DIV_RESULT_NOT_READY = 1'b0;

    // Request levels driven by EX
    localparam logic DIV_START = 1'b1;
    localparam logic DIV_STOP  = 1'b0;

    // aluop codes that EX decodes into start_i / signed_div_i
    localparam logic [7:0] ALU_DIV  = 8'b0001_1010;
    localparam logic [7:0] ALU_DIVU = 8'b0001_1011;

endpackage
`default_nettype wire

// File: rtl/div.sv
`default_nettype none
// ============================================================================
//  Module      : div
//  Description : Radix-2 restoring divider, one quotient bit per clock.
//                Signed operation divides magnitudes and fixes signs at the
//                end. Result is {remainder, quotient}, held until EX drops
//                start_i. annul_i aborts an in-flight division.
//  Revision    : 1.0  initial release
// ============================================================================
module div
    import div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 signed_div_i,
    input  logic [WIDTH-1:0]     opdata1_i,
    input  logic [WIDTH-1:0]     opdata2_i,
    input  logic                 start_i,
    input  logic                 annul_i,
    output logic [2*WIDTH-1:0]   result_o,
    output logic                 ready_o
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] c_last_cnt = CNT_W'(WIDTH - 1);

    logic [1:0]          state_q,    state_d;
    logic [WIDTH-1:0]    dividend_q, dividend_d;   // shifts dividend out, quotient in
    logic [WIDTH-1:0]    divisor_q,  divisor_d;
    logic [WIDTH-1:0]    rem_q,      rem_d;
    logic [CNT_W-1:0]    cnt_q,      cnt_d;
    logic                sign1_q,    sign1_d;
    logic                sign2_q,    sign2_d;
    logic                sdiv_q,     sdiv_d;
    logic [2*WIDTH-1:0]  result_q,   result_d;
    logic                ready_q,    ready_d;

    logic                w_req;
    logic                w_neg1;
    logic                w_neg2;
    logic [WIDTH+1:0]    w_partial;
    logic                w_qbit;
    logic [WIDTH-1:0]    w_rem_next;
    logic [WIDTH-1:0]    w_quot_next;
    logic [WIDTH-1:0]    w_rem_fix;
    logic [WIDTH-1:0]    w_quot_fix;

    // A request counts only when it is not annulled in the same cycle
    assign w_req  = start_i & ~annul_i;
    assign w_neg1 = signed_div_i & opdata1_i[WIDTH-1];
    assign w_neg2 = signed_div_i & opdata2_i[WIDTH-1];

    // Single restoring step; the extra top bit of the subtract is the borrow
    always_comb begin
        w_partial   = {1'b0, rem_q, dividend_q[WIDTH-1]} - {2'b00, divisor_q};
        w_qbit      = ~w_partial[WIDTH+1];
        w_rem_next  = w_qbit ? w_partial[WIDTH-1:0]
                             : {rem_q[WIDTH-2:0], dividend_q[WIDTH-1]};
        w_quot_next = {dividend_q[WIDTH-2:0], w_qbit};
        w_quot_fix  = (sdiv_q && (sign1_q ^ sign2_q)) ? -w_quot_next : w_quot_next;
        w_rem_fix   = (sdiv_q && sign1_q) ? -w_rem_next : w_rem_next;
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= DIV_FREE;
            dividend_q <= '0;
            divisor_q  <= '0;
            rem_q      <= '0;
            cnt_q      <= '0;
            sign1_q    <= 1'b0;
            sign2_q    <= 1'b0;
            sdiv_q     <= 1'b0;
            result_q   <= '0;
            ready_q    <= DIV_RESULT_NOT_READY;
        end else begin
            state_q    <= state_d;
            dividend_q <= dividend_d;
            divisor_q  <= divisor_d;
            rem_q      <= rem_d;
            cnt_q      <= cnt_d;
            sign1_q    <= sign1_d;
            sign2_q    <= sign2_d;
            sdiv_q     <= sdiv_d;
            result_q   <= result_d;
            ready_q    <= ready_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            DIV_FREE: begin
                if (w_req) begin
                    state_d = (opdata2_i == '0) ? DIV_BYZERO : DIV_ON;
                end
            end
            DIV_BYZERO: state_d = DIV_END;
            DIV_ON: begin
                if (annul_i) begin
                    state_d = DIV_FREE;
                end else if (cnt_q == c_last_cnt) begin
                    state_d = DIV_END;
                end
            end
            DIV_END: begin
                if (!start_i || annul_i) begin
                    state_d = DIV_FREE;
                end
            end
            default: state_d = DIV_FREE;
        endcase
    end

    // Datapath and output updates per state
    always_comb begin
        dividend_d = dividend_q;
        divisor_d  = divisor_q;
        rem_d      = rem_q;
        cnt_d      = cnt_q;
        sign1_d    = sign1_q;
        sign2_d    = sign2_q;
        sdiv_d     = sdiv_q;
        result_d   = result_q;
        ready_d    = ready_q;
        case (state_q)
            DIV_FREE: begin
                result_d = '0;
                ready_d  = DIV_RESULT_NOT_READY;
                if (w_req && (opdata2_i != '0)) begin
                    dividend_d = w_neg1 ? -opdata1_i : opdata1_i;
                    divisor_d  = w_neg2 ? -opdata2_i : opdata2_i;
                    rem_d      = '0;
                    cnt_d      = '0;
                    sign1_d    = opdata1_i[WIDTH-1];
                    sign2_d    = opdata2_i[WIDTH-1];
                    sdiv_d     = signed_div_i;
                end
            end
            DIV_BYZERO: begin
                result_d = '0;
                ready_d  = DIV_RESULT_READY;
            end
            DIV_ON: begin
                if (annul_i) begin
                    result_d = '0;
                    ready_d  = DIV_RESULT_NOT_READY;
                end else begin
                    dividend_d = w_quot_next;
                    rem_d      = w_rem_next;
                    cnt_d      = cnt_q + 1'b1;
                    if (cnt_q == c_last_cnt) begin
                        result_d = {w_rem_fix, w_quot_fix};
                        ready_d  = DIV_RESULT_READY;
                    end
                end
            end
            DIV_END: begin
                if (!start_i || annul_i) begin
                    result_d = '0;
                    ready_d  = DIV_RESULT_NOT_READY;
                end
            end
            default: begin
                result_d = '0;
                ready_d  = DIV_RESULT_NOT_READY;
            end
        endcase
    end

    assign result_o = result_q;
    assign ready_o  = ready_q;

endmodule
`default_nettype wire

// File: tb/tb_div.sv
`default_nettype none
// ============================================================================
//  Module      : tb_div
//  Description : Directed self-checking bench for the divider. Expected
//                results come from plain 64-bit arithmetic; a single compare
//                process checks ready_o/result_o on every falling edge.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_div;

    logic        clk = 1'b0;
    logic        rst;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;

    int          n_vec = 0;
    int          n_bad = 0;
    bit          chk_en = 1'b0;
    bit          exp_ready = 1'b0;
    logic [63:0] exp_result = '0;

    div #(.WIDTH(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o)
    );

    always #5 clk = ~clk;

    // Architectural result: truncating division, remainder takes dividend sign
    function automatic logic [63:0] model(input bit sd, input logic [31:0] a,
                                          input logic [31:0] b);
        longint sa, sb, q, r;
        if (b == 32'h0) return 64'h0;
        if (sd) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'h0, a});
            sb = longint'({32'h0, b});
        end
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    // Compare process: outputs are meaningful on every cycle after reset
    always @(negedge clk) begin
        if (chk_en) begin
            logic [63:0] want;
            want = exp_ready ? exp_result : 64'h0;
            n_vec++;
            if (ready_o !== exp_ready) begin
                n_bad++;
                $display("FAIL ready: got %0b want %0b at %0t", ready_o, exp_ready, $time);
            end
            n_vec++;
            if (result_o !== want) begin
                n_bad++;
                $display("FAIL result: got %h want %h at %0t", result_o, want, $time);
            end
        end
    end

    // One division request. abort_at >= 1 aborts after that edge of ON,
    // via rst when abort_rst is set, else via annul_i.
    task automatic do_div(input bit sd, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] want, input int hold,
                          input int abort_at, input bit abort_rst, input bit scramble);
        int lat;
        n_vec++;
        if (model(sd, a, b) !== want) begin
            n_bad++;
            $display("FAIL model %h/%h: got %h want %h", a, b, model(sd, a, b), want);
        end
        lat          = (b == 32'h0) ? 1 : 32;
        signed_div_i = sd;
        opdata1_i    = a;
        opdata2_i    = b;
        start_i      = 1'b1;
        exp_ready    = 1'b0;
        for (int k = 0; k <= lat; k++) begin
            @(posedge clk); #1;
            if (k == 0 && scramble) begin
                opdata1_i = ~a;
                opdata2_i = 32'h3;
            end
            if (k == abort_at) begin
                if (abort_rst) rst = 1'b1;
                else           annul_i = 1'b1;
                @(posedge clk); #1;
                rst     = 1'b0;
                annul_i = 1'b0;
                start_i = 1'b0;
                @(posedge clk); #1;
                return;
            end
            if (k == lat) begin
                exp_result = model(sd, a, b);
                exp_ready  = 1'b1;
            end
        end
        repeat (hold) begin
            @(posedge clk); #1;
        end
        start_i = 1'b0;
        @(posedge clk); #1;
        exp_ready = 1'b0;
    endtask

    initial begin
        rst          = 1'b1;
        signed_div_i = 1'b0;
        opdata1_i    = '0;
        opdata2_i    = '0;
        start_i      = 1'b0;
        annul_i      = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_en = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        do_div(1'b0, 32'd7,        32'd2,        64'h00000001_00000003, 2, -1, 1'b0, 1'b0);
        do_div(1'b1, 32'hFFFFFFF9, 32'h00000002, 64'hFFFFFFFF_FFFFFFFD, 1, -1, 1'b0, 1'b0);
        do_div(1'b1, 32'd7,        32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 1, -1, 1'b0, 1'b0);
        do_div(1'b0, 32'h12345678, 32'h0,        64'h00000000_00000000, 3, -1, 1'b0, 1'b0);
        do_div(1'b1, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 1, -1, 1'b0, 1'b0);
        do_div(1'b0, 32'hFFFFFFFF, 32'h1,        64'h00000000_FFFFFFFF, 0, -1, 1'b0, 1'b0);
        do_div(1'b0, 32'd1234,     32'd5,        64'h00000004_000000F6, 0, 10, 1'b0, 1'b0);
        do_div(1'b0, 32'd100,      32'd7,        64'h00000002_0000000E, 5, -1, 1'b0, 1'b0);
        do_div(1'b1, 32'hFFFFFC18, 32'd3,        64'hFFFFFFFF_FFFFFEB3, 0, 20, 1'b1, 1'b0);
        do_div(1'b1, 32'hFFFFFC18, 32'd3,        64'hFFFFFFFF_FFFFFEB3, 1, -1, 1'b0, 1'b0);
        do_div(1'b0, 32'hDEADBEEF, 32'd10,       64'h00000009_16449317, 2, -1, 1'b0, 1'b1);

        repeat (3) @(posedge clk);
        #1;
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
